// File: rtl/auv_heading_ctrl_if.sv
// Handshake/data bundle between triangulation, heading generator and thruster controller.
// master: upstream/downstream side; slave: the heading generator itself.
interface auv_heading_ctrl_if #(
    parameter int unsigned AXES    = 3,
    parameter int unsigned COORD_W = 8,
    parameter int unsigned HEAD_W  = COORD_W + 1
);
    logic                      in_valid;
    logic                      in_ready;
    logic [AXES*COORD_W-1:0]   pinger_pos;
    logic [AXES*COORD_W-1:0]   auv_pos;
    logic                      out_valid;
    logic                      out_ready;
    logic [AXES*HEAD_W-1:0]    heading;
    logic                      arrived;
    logic                      stale;

    modport master (
        output in_valid, pinger_pos, auv_pos, out_ready,
        input  in_ready, out_valid, heading, arrived, stale
    );

    modport slave (
        input  in_valid, pinger_pos, auv_pos, out_ready,
        output in_ready, out_valid, heading, arrived, stale
    );
endinterface

// File: rtl/auv_heading_ctrl.sv
// Registered AUV heading generator: per-axis (pinger - auv) with deadband, saturation and a
// staleness timer. Define HEADING_IIR_EN to add a first-order smoothing filter on the heading.
module auv_heading_ctrl #(
    parameter int unsigned AXES      = 3,
    parameter int unsigned COORD_W   = 8,
    parameter int unsigned HEAD_W    = COORD_W + 1,
    parameter int          DEADBAND  = 2,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned IIR_SHIFT = 2
) (
    input logic             clk,
    input logic             rst_n,
    auv_heading_ctrl_if.slave bus
);
    localparam int unsigned DW     = COORD_W + 2;
    localparam int unsigned FW     = HEAD_W + 1;
    localparam int          HMAX_I = (1 <<< (HEAD_W - 1)) - 1;
    localparam int unsigned TW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    localparam logic signed [DW-1:0] DB_P   = DW'(DEADBAND);
    localparam logic signed [DW-1:0] DB_N   = -DB_P;
    localparam logic signed [DW-1:0] HMAX_W = DW'(HMAX_I);
    localparam logic signed [DW-1:0] HMIN_W = DW'(-HMAX_I - 1);

    if (AXES < 1 || HEAD_W < 2 || HEAD_W > COORD_W + 1 || IIR_SHIFT >= 32) begin : g_bad_param
        $error("auv_heading_ctrl: illegal parameter combination");
    end

    typedef enum logic [1:0] {StIdle, StCalc, StOut} state_e;

    state_e                   state_q;
    logic [AXES*COORD_W-1:0]  pinger_q;
    logic [AXES*COORD_W-1:0]  auv_q;
    logic [AXES*HEAD_W-1:0]   heading_q;
    logic [AXES*HEAD_W-1:0]   head_next;
    logic [AXES-1:0]          axis_zero;
    logic                     out_valid_q;
    logic                     arrived_q;
    logic [TW-1:0]            timer_q;
    logic                     accept;
`ifdef HEADING_IIR_EN
    logic                     loaded_q;
`endif

    assign accept        = (state_q == StIdle) && bus.in_valid;
    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.heading   = heading_q;
    assign bus.arrived   = arrived_q;
    assign bus.stale     = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT));

    for (genvar g = 0; g < AXES; g++) begin : g_axis
        logic signed [DW-1:0]     diff;
        logic signed [HEAD_W-1:0] tgt;

        // Both operands zero-extended, so the difference is exact at COORD_W+1 bits.
        assign diff = $signed({2'b00, pinger_q[g*COORD_W +: COORD_W]})
                    - $signed({2'b00, auv_q[g*COORD_W +: COORD_W]});

        always_comb begin
            if (diff <= DB_P && diff >= DB_N) begin
                tgt = '0;
            end else if (diff > HMAX_W) begin
                tgt = HMAX_W[HEAD_W-1:0];
            end else if (diff < HMIN_W) begin
                tgt = HMIN_W[HEAD_W-1:0];
            end else begin
                tgt = diff[HEAD_W-1:0];
            end
        end

        assign axis_zero[g] = (tgt == '0);

`ifdef HEADING_IIR_EN
        localparam logic signed [FW-1:0] FMAX = FW'(HMAX_I);
        localparam logic signed [FW-1:0] FMIN = FW'(-HMAX_I - 1);

        logic signed [FW-1:0]     tw;
        logic signed [FW-1:0]     pw;
        logic signed [FW-1:0]     step;
        logic signed [FW-1:0]     sum;
        logic signed [HEAD_W-1:0] filt;

        assign tw   = {tgt[HEAD_W-1], tgt};
        assign pw   = {heading_q[g*HEAD_W+HEAD_W-1], heading_q[g*HEAD_W +: HEAD_W]};
        assign step = (tw - pw) >>> IIR_SHIFT;
        assign sum  = pw + step;

        always_comb begin
            if (sum > FMAX) begin
                filt = FMAX[HEAD_W-1:0];
            end else if (sum < FMIN) begin
                filt = FMIN[HEAD_W-1:0];
            end else begin
                filt = sum[HEAD_W-1:0];
            end
        end

        // First result after reset has no history to smooth against.
        assign head_next[g*HEAD_W +: HEAD_W] = loaded_q ? filt : tgt;
`else
        assign head_next[g*HEAD_W +: HEAD_W] = tgt;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            pinger_q    <= '0;
            auv_q       <= '0;
            heading_q   <= '0;
            arrived_q   <= 1'b0;
            out_valid_q <= 1'b0;
            timer_q     <= '0;
`ifdef HEADING_IIR_EN
            loaded_q    <= 1'b0;
`endif
        end else begin
            // An accept always wins over the timer reaching TIMEOUT.
            if (accept) begin
                timer_q <= '0;
            end else if (timer_q != TW'(TIMEOUT)) begin
                timer_q <= timer_q + 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        pinger_q <= bus.pinger_pos;
                        auv_q    <= bus.auv_pos;
                        state_q  <= StCalc;
                    end
                end
                StCalc: begin
                    heading_q   <= head_next;
                    arrived_q   <= &axis_zero;
                    out_valid_q <= 1'b1;
                    state_q     <= StOut;
`ifdef HEADING_IIR_EN
                    loaded_q    <= 1'b1;
`endif
                end
                StOut: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end
endmodule

// File: doc/auv_heading_ctrl.md
Name: auv_heading_ctrl

Overview:
Parametrised, registered heading generator for the AUV navigation path. It accepts pinger and AUV position vectors over a valid/ready handshake and computes a signed per-axis heading vector (pinger minus AUV). Each axis is saturated and deadbanded, and an arrival flag is produced. A staleness timer flags when no fresh position fix has arrived. The block sits between the triangulation stage and the thruster/attitude controller.

Parameters:
AXES, 3, number of spatial axes (>=1)
COORD_W, 8, width of each unsigned input coordinate
HEAD_W, COORD_W+1, width of each signed output heading component (2..COORD_W+1)
DEADBAND, 2, per-axis magnitude at or below which the heading component is forced to 0
TIMEOUT, 16, cycles without an accepted input before stale asserts; 0 disables the timer
IIR_SHIFT, 2, smoothing shift used only with HEADING_IIR_EN

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input vector valid
in_ready  out  1  block can accept input
pinger_pos  in  AXES*COORD_W  pinger position, axis 0 in LSBs, unsigned
auv_pos  in  AXES*COORD_W  AUV position, same packing
out_valid  out  1  heading valid
out_ready  in  1  downstream accepts heading
heading  out  AXES*HEAD_W  signed heading, axis 0 in LSBs, two's complement
arrived  out  1  all heading components zero after deadband; qualified by out_valid
stale  out  1  no input accepted for TIMEOUT cycles

Behaviour:
- One clock domain (clk). rst_n is asynchronous assert, synchronous deassert externally guaranteed, active-low.
- Reset values: state=IDLE, in_ready=1 (after reset release), out_valid=0, heading=0, arrived=0, stale=0, timer=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&&in_ready, capture both vectors and go to CALC.
  - CALC: in_ready=0. Compute and register heading/arrived, set out_valid=1, go to OUT.
  - OUT: in_ready=0. heading, arrived and out_valid stay stable until out_ready=1. On that edge, out_valid goes to 0 and the FSM returns to IDLE.
- Latency and throughput: input accepted at edge N gives out_valid=1 after edge N+1, visible in cycle N+2. Peak throughput is one vector per 3 cycles while out_ready is held high.
- in_valid is ignored outside IDLE. Upstream must hold data until accepted.
- Arithmetic, per axis:
  - d = zero-extended pinger minus zero-extended auv, signed COORD_W+1 bits, exact.
  - If |d| <= DEADBAND, the component is 0.
  - Otherwise clamp to [-2^(HEAD_W-1), 2^(HEAD_W-1)-1].
  - No wrap-around is permitted at any width.
- arrived = 1 iff every post-deadband component is 0. arrived is registered with heading.
- Timer:
  - Increments every cycle no input is accepted and saturates at TIMEOUT.
  - Cleared to 0 on the accept edge.
  - stale = (timer == TIMEOUT) && TIMEOUT != 0.
  - stale never alters heading.
- Simultaneous events: in IDLE, an accept edge clears the timer even if the timer would otherwise reach TIMEOUT in that cycle.
- Reset mid-operation: the in-flight vector is discarded. out_valid drops immediately (asynchronously) and all outputs return to reset values.

Optional Feature:
HEADING_IIR_EN
- Defined: the registered heading becomes prev + ((target - prev) >>> IIR_SHIFT), computed per axis at HEAD_W+1 bits and then clamped.
  - target is the saturated, deadbanded value.
  - The first output after reset loads target directly.
  - arrived is computed from target, not from the filtered value.
  - Latency is unchanged.
- Undefined: heading = target. No filter state registers are present.

Test Plan:
1. Defaults. pinger=(100,50,10), auv=(40,60,10), out_ready=1 -> heading=(60,-10,0), arrived=0, out_valid high 2 cycles after accept for exactly 1 cycle.
2. Extremes. pinger=(0,255,128), auv=(255,0,128) -> HEAD_W=9: (-255,255,0). Rebuilt with HEAD_W=8: (-128,127,0), no wrap.
3. Deadband. pinger=(12,10,9), auv=(10,10,10) -> heading=(0,0,0), arrived=1. pinger=(13,10,10) -> (3,0,0), arrived=0.
4. Backpressure. out_ready=0 for 5 cycles after out_valid -> heading/arrived stable, in_ready=0, a new in_valid is ignored. out_ready=1 -> IDLE next cycle, then the new vector is accepted.
5. Stale. No input for 16 cycles after reset -> stale=1 from cycle 16. An accept clears stale the following cycle. Rebuilt with TIMEOUT=0 -> stale stays 0.
6. Reset in OUT with out_ready=0 -> out_valid/heading go to 0 while rst_n=0. After release in_ready=1. With HEADING_IIR_EN and IIR_SHIFT=2: targets 64 then 0 on axis 0 -> outputs 64, then 48.
